div_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one sequential Q16.16 unsigned divider (48-iteration

---
 rtl/div_rr_sched_if.sv | 18 +
 rtl/div_rr_sched.sv | 105 ++++++++++
 tb/tb_div_rr_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div_rr_sched_if.sv
// div_rr_sched_if: request/response bus between requesters and the divider scheduler
// Ports: req_valid/req_a/req_b (requester -> scheduler), req_ready (one-hot grant),
//   rsp_valid (one-hot result strobe), rsp_q (Q16.16 result), rsp_div0/rsp_tmo (error flags)
interface div_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_q;
  logic                  rsp_div0;
  logic                  rsp_tmo;
  modport master (output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_q, rsp_div0, rsp_tmo);
  modport slave  (input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_q, rsp_div0, rsp_tmo);
endinterface

// File: rtl/div_rr_sched.sv
// div_rr_sched: round-robin scheduler sharing one sequential Q16.16 divider among NREQ requesters
// Ports: clk, rst_n (async active-low); bus (slave side of div_rr_sched_if) carries requests and
//   one-hot results; busy_o high outside IDLE; div_valid_o/div_a_o/div_b_o drive the divider,
//   div_valid_i/div_q_i return its result.
module div_rr_sched #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 32,
  parameter int DIV_ITER = 48,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  div_rr_sched_if.slave    bus,
  output logic             busy_o,
  output logic             div_valid_o,
  output logic [WIDTH-1:0] div_a_o,
  output logic [WIDTH-1:0] div_b_o,
  input  logic             div_valid_i,
  input  logic [WIDTH-1:0] div_q_i
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT > DIV_ITER + 2 ? TIMEOUT : DIV_ITER + 3);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t           st;
  logic [PW-1:0]    ptr, own, gnt;
  logic [CW-1:0]    cnt;
  logic [NREQ-1:0]  above;
  logic [WIDTH-1:0] a_sel, b_sel;
  always_comb begin
    above = '0;
    gnt   = '0;
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) above[k] = bus.req_valid[k] && (k >= int'(ptr));
    for (int k = NREQ - 1; k >= 0; k--) if (bus.req_valid[k]) gnt = PW'(k);
    for (int k = NREQ - 1; k >= 0; k--) if (above[k]) gnt = PW'(k);
    for (int k = 0; k < NREQ; k++) begin
      if (k == int'(gnt)) begin
        a_sel = bus.req_a[k*WIDTH +: WIDTH];
        b_sel = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end
  assign bus.req_ready = (st == IDLE && |bus.req_valid) ? NREQ'(1) << gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      ptr           <= '0;
      own           <= '0;
      cnt           <= '0;
      busy_o        <= 1'b0;
      div_valid_o   <= 1'b0;
      div_a_o       <= '0;
      div_b_o       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_q     <= '0;
      bus.rsp_div0  <= 1'b0;
      bus.rsp_tmo   <= 1'b0;
    end else begin
      case (st)
        IDLE: if (|bus.req_valid) begin
          own    <= gnt;
          ptr    <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          busy_o <= 1'b1;
          if (b_sel == '0) begin
            st            <= DONE;
            bus.rsp_q     <= '1;
            bus.rsp_div0  <= 1'b1;
            bus.rsp_valid <= NREQ'(1) << gnt;
          end else begin
            st          <= ISSUE;
            div_valid_o <= 1'b1;
            div_a_o     <= a_sel;
            div_b_o     <= b_sel;
          end
        end
        ISSUE: begin
          st          <= WAIT;
          div_valid_o <= 1'b0;
          cnt         <= '0;
        end
        WAIT: if (div_valid_i) begin
          st            <= DONE;
          bus.rsp_q     <= div_q_i;
          bus.rsp_valid <= NREQ'(1) << own;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          st            <= DONE;
          bus.rsp_q     <= '0;
          bus.rsp_tmo   <= 1'b1;
          bus.rsp_valid <= NREQ'(1) << own;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          st            <= IDLE;
          busy_o        <= 1'b0;
          bus.rsp_valid <= '0;
          bus.rsp_div0  <= 1'b0;
          bus.rsp_tmo   <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_rr_sched.sv
// tb_div_rr_sched: scoreboard bench for div_rr_sched with a behavioural 48-iteration divider
module tb_div_rr_sched;
  localparam int NREQ = 4, W = 32, DIV_ITER = 48, TIMEOUT = 64;
  localparam int LAT_NORM = DIV_ITER + 3, LAT_TMO = TIMEOUT + 1, LAT_D0 = 0;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  div_rr_sched_if #(.NREQ(NREQ), .WIDTH(W)) bus ();
  logic busy, dvo, dvi;
  logic [W-1:0] da, db, dq;
  div_rr_sched #(.NREQ(NREQ), .WIDTH(W), .DIV_ITER(DIV_ITER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy),
    .div_valid_o(dvo), .div_a_o(da), .div_b_o(db), .div_valid_i(dvi), .div_q_i(dq)
  );
  typedef struct {int own; logic [W-1:0] q; bit d0; bit tmo; int acc; int lat;} exp_t;
  exp_t sb[$];
  exp_t ne, me;
  int gord[$];
  int ord[5] = '{0, 1, 2, 3, 0};
  logic [W-1:0] exp_q [NREQ];
  int pass = 0, total = 0, cyc = 0, mptr = 0, acc_cnt = 0, done_cnt = 0, starts = 0, eg;
  bit hang = 0, idle_rep = 0;
  logic running, mvld;
  int mcnt;
  logic [W-1:0] mq;
  logic [NREQ-1:0] prev_rv = '0;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  always @(posedge clk) cyc++;
  always @(posedge clk) if (dvo) starts++;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      mcnt    <= 0;
      mvld    <= 1'b0;
      mq      <= '0;
    end else begin
      mvld <= 1'b0;
      if (dvo) begin
        running <= 1'b1;
        mcnt    <= 1;
        mq      <= W'({da, 16'h0} / {16'h0, db});
      end else if (running && !hang) begin
        mcnt <= mcnt + 1;
        if (mcnt == DIV_ITER + 1) begin
          mvld    <= 1'b1;
          running <= 1'b0;
        end
      end
    end
  end
  assign dvi = mvld | (idle_rep & ~running);
  assign dq  = mvld ? mq : 32'hDEAD_BEEF;
  always @(negedge clk) begin
    if (!rst_n) mptr = 0;
    else if ((bus.req_valid & bus.req_ready) != '0) begin
      eg = -1;
      for (int k = 0; k < NREQ; k++)
        if (eg < 0 && bus.req_valid[(mptr + k) % NREQ]) eg = (mptr + k) % NREQ;
      chk("grant", bus.req_ready, 64'(1) << eg);
      chk("one_outstanding", sb.size(), 0);
      ne.own = eg;
      ne.d0  = bus.req_b[eg*W +: W] == '0;
      ne.tmo = hang && !ne.d0;
      ne.q   = exp_q[eg];
      ne.acc = cyc + 1;
      ne.lat = ne.d0 ? LAT_D0 : (hang ? LAT_TMO : LAT_NORM);
      sb.push_back(ne);
      gord.push_back(eg);
      mptr = (eg + 1) % NREQ;
      acc_cnt++;
    end
  end
  always @(negedge clk) begin
    if (rst_n && prev_rv != '0) chk("rsp_pulse", bus.rsp_valid, 0);
    prev_rv = bus.rsp_valid;
    if (rst_n && bus.rsp_valid != '0) begin
      if (sb.size() == 0) chk("spurious_rsp", bus.rsp_valid, 0);
      else begin
        me = sb.pop_front();
        chk("rsp_owner", bus.rsp_valid, 64'(1) << me.own);
        chk("rsp_q", bus.rsp_q, me.q);
        chk("rsp_div0", bus.rsp_div0, me.d0);
        chk("rsp_tmo", bus.rsp_tmo, me.tmo);
        chk("latency", cyc - me.acc, me.lat);
        done_cnt++;
      end
    end
  end
  task automatic issue(int i, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] q);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    exp_q[i] = q;
    bus.req_valid[i] = 1'b1;
  endtask
  task automatic wait_acc(int n, int budget);
    int t = 0;
    while (acc_cnt < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (acc_cnt < n) chk("accept_wait", acc_cnt, n);
  endtask
  task automatic wait_done(int n, int budget);
    int t = 0;
    while (done_cnt < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt < n) chk("response_wait", done_cnt, n);
  endtask
  task automatic run1(int i, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] q);
    int na = acc_cnt + 1, nd = done_cnt + 1;
    issue(i, a, b, q);
    wait_acc(na, 20);
    #1 bus.req_valid[i] = 1'b0;
    wait_done(nd, 100);
    #1 chk("busy_after", busy, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s, na, nd;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", {busy, dvo, bus.rsp_div0, bus.rsp_tmo, bus.rsp_valid, bus.req_ready}, 0);
    chk("reset_rsp_q", bus.rsp_q, 0);
    chk("reset_div_ab", {da, db}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) issue(i, W'(i + 1), 1, W'(i + 1) << 16);
    wait_acc(5, 400);
    #1 bus.req_valid = '0;
    wait_done(5, 200);
    #1 chk("grant_count", gord.size(), 5);
    for (int k = 0; k < 5; k++) chk("grant_order", gord[k], ord[k]);
    run1(0, 3, 2, 32'h0001_8000);
    s = starts;
    run1(2, 1, 0, 32'hFFFF_FFFF);
    chk("div0_no_start", starts, s);
    idle_rep = 1'b1;
    repeat (10) @(posedge clk);
    #1 run1(0, 5, 2, 32'h0002_8000);
    idle_rep = 1'b0;
    hang = 1'b1;
    run1(3, 9, 3, 32'h0);
    hang = 1'b0;
    run1(0, 1, 3, 32'h0000_5555);
    na = acc_cnt + 1;
    issue(1, 7, 3, 32'h0002_5555);
    wait_acc(na, 20);
    #1 bus.req_valid[1] = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {busy, dvo, bus.rsp_div0, bus.rsp_tmo, bus.rsp_valid, bus.req_ready}, 0);
    chk("abort_rsp_q", bus.rsp_q, 0);
    chk("abort_div_ab", {da, db}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    na = acc_cnt + 1;
    nd = done_cnt + 2;
    issue(1, 10, 4, 32'h0002_8000);
    issue(3, 1, 4, 32'h0000_4000);
    @(negedge clk);
    chk("ptr_after_reset", bus.req_ready, 4'b0010);
    wait_acc(na, 20);
    #1 bus.req_valid[1] = 1'b0;
    wait_acc(na + 1, 100);
    #1 bus.req_valid[3] = 1'b0;
    wait_done(nd, 200);
    repeat (4) @(posedge clk);
    #1 chk("final_idle", {busy, bus.req_ready}, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
